// File: rtl/q2_pkg.sv
// Shared definitions for the Q2 accumulator CPU: opcodes, OPR bit positions,
// sequencer states and effective-address helper.
package q2_pkg;

  localparam logic [2:0] OP_LEA = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_LDA = 3'd3;
  localparam logic [2:0] OP_STA = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_JSR = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  localparam int unsigned OPR_CLA = 0;
  localparam int unsigned OPR_CLC = 1;
  localparam int unsigned OPR_CMA = 2;
  localparam int unsigned OPR_INA = 3;
  localparam int unsigned OPR_RAR = 4;
  localparam int unsigned OPR_RAL = 5;
  localparam int unsigned OPR_SZA = 6;
  localparam int unsigned OPR_SNC = 7;
  localparam int unsigned OPR_HLT = 8;

  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH,
`ifdef Q2_INDIRECT_EN
    S_IND,
`endif
    S_EXEC,
    S_ST1,
    S_ST2,
    S_PW1,
    S_PW2
  } state_t;

  // Page-zero or current-page address; page is taken from the incremented P.
  function automatic logic [11:0] ea_of(input logic r, input logic [6:0] offset,
                                        input logic [4:0] page);
    return r ? {page, offset} : {5'b0, offset};
  endfunction

endpackage

// File: rtl/q2_alu.sv
// Combinational Q2 ALU: memory-reference arithmetic and the ordered OPR
// micro-operations, with the skip decision taken on the final A and C.
module q2_alu
  import q2_pkg::*;
(
  input  logic [11:0] a,
  input  logic        c,
  input  logic [11:0] operand,
  input  logic [2:0]  opcode,
  input  logic [8:0]  opr_bits,
  output logic [11:0] a_new,
  output logic        c_new,
  output logic        skip
);

  logic [12:0] sum;
  logic [11:0] ta;
  logic        tc;

  always_comb begin
    a_new = a;
    c_new = c;
    skip  = 1'b0;
    sum   = '0;
    ta    = a;
    tc    = c;
    case (opcode)
      OP_LEA: a_new = operand;
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, operand};
        a_new = sum[11:0];
        c_new = sum[12];
      end
      OP_AND: a_new = a & operand;
      OP_LDA: a_new = operand;
      OP_OPR: begin
        if (opr_bits[OPR_CLA]) ta = '0;
        if (opr_bits[OPR_CLC]) tc = 1'b0;
        if (opr_bits[OPR_CMA]) ta = ~ta;
        if (opr_bits[OPR_INA]) begin
          sum = {1'b0, ta} + 13'd1;
          ta  = sum[11:0];
          tc  = sum[12];
        end
        // 13-bit rotate through carry; both directions together cancel out.
        if (opr_bits[OPR_RAR] && !opr_bits[OPR_RAL]) begin
          {ta, tc} = {tc, ta};
        end else if (opr_bits[OPR_RAL] && !opr_bits[OPR_RAR]) begin
          {tc, ta} = {ta, tc};
        end
        skip  = (opr_bits[OPR_SZA] && (ta == '0)) || (opr_bits[OPR_SNC] && !tc);
        a_new = ta;
        c_new = tc;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/q2_core.sv
// Q2 core: instruction sequencer, registers, EA logic, panel switch handling
// and data-bus tristate. Q2_INDIRECT_EN enables the indirect (IND) cycle.
module q2_core
  import q2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sw,
  inout  wire  [11:0] dbus,
  output logic [11:0] abus,
  output logic        rdm,
  output logic        wrm,
  input  logic        incp_sw,
  input  logic        dep_sw,
  input  logic        start_sw,
  input  logic        stop_sw,
  output logic        run
);

  state_t      state, state_n;
  logic [11:0] p, p_n, a, a_n, ir, ir_n, ea, ea_n;
  logic        c, c_n, run_n;
  logic [11:0] abus_n, dout, dout_n;
  logic        rdm_n, wrm_n, doe, doe_n;
  logic        dep_q, incp_q, start_q;
  logic        dep_edge, incp_edge, start_edge;
  logic [11:0] pc_inc, fetch_ea, disp_ea, alu_operand, alu_a;
  logic [2:0]  disp_op;
  logic        dispatch, boundary, halt_now, alu_c, alu_skip;

  assign dep_edge   = dep_sw & ~dep_q;
  assign incp_edge  = incp_sw & ~incp_q;
  assign start_edge = start_sw & ~start_q;

  assign pc_inc      = p + 12'd1;
  assign fetch_ea    = ea_of(dbus[7], dbus[6:0], pc_inc[11:7]);
  assign alu_operand = (ir[11:9] == OP_LEA) ? ea : dbus;
  assign dbus        = doe ? dout : 'z;

  q2_alu u_alu (
    .a        (a),
    .c        (c),
    .operand  (alu_operand),
    .opcode   (ir[11:9]),
    .opr_bits (ir[8:0]),
    .a_new    (alu_a),
    .c_new    (alu_c),
    .skip     (alu_skip)
  );

  always_comb begin
    state_n  = state;
    p_n      = p;
    a_n      = a;
    c_n      = c;
    ir_n     = ir;
    ea_n     = ea;
    run_n    = run;
    abus_n   = abus;
    rdm_n    = 1'b0;
    wrm_n    = 1'b0;
    doe_n    = 1'b0;
    dout_n   = dout;
    dispatch = 1'b0;
    boundary = 1'b0;
    halt_now = 1'b0;
    disp_op  = ir[11:9];
    disp_ea  = ea;
    case (state)
      S_HALT: begin
        if (dep_edge) begin
          state_n = S_PW1;
          abus_n  = p;
          doe_n   = 1'b1;
          dout_n  = sw;
        end else if (incp_edge) begin
          p_n = pc_inc;
        end else if (start_edge && !stop_sw) begin
          state_n = S_FETCH;
          run_n   = 1'b1;
          abus_n  = p;
          rdm_n   = 1'b1;
        end
      end
      S_FETCH: begin
        ir_n    = dbus;
        p_n     = pc_inc;
        ea_n    = fetch_ea;
        disp_op = dbus[11:9];
        disp_ea = fetch_ea;
`ifdef Q2_INDIRECT_EN
        // OPR reuses bit 8 as HLT, so it never takes the indirect cycle.
        if (dbus[8] && (dbus[11:9] != OP_OPR)) begin
          state_n = S_IND;
          abus_n  = fetch_ea;
          rdm_n   = 1'b1;
        end else begin
          dispatch = 1'b1;
        end
`else
        dispatch = 1'b1;
`endif
      end
`ifdef Q2_INDIRECT_EN
      S_IND: begin
        ea_n     = dbus;
        disp_ea  = dbus;
        dispatch = 1'b1;
      end
`endif
      S_EXEC: begin
        a_n = alu_a;
        c_n = alu_c;
        if (ir[11:9] == OP_JMP) p_n = ea;
        if (ir[11:9] == OP_OPR) begin
          if (alu_skip) p_n = pc_inc;
          halt_now = ir[OPR_HLT];
        end
        boundary = 1'b1;
      end
      S_ST1: begin
        state_n = S_ST2;
        wrm_n   = 1'b1;
        doe_n   = 1'b1;
      end
      S_ST2: begin
        if (ir[11:9] == OP_JSR) p_n = ea + 12'd1;
        boundary = 1'b1;
      end
      S_PW1: begin
        state_n = S_PW2;
        wrm_n   = 1'b1;
        doe_n   = 1'b1;
      end
      S_PW2: begin
        p_n     = pc_inc;
        state_n = S_HALT;
      end
      default: state_n = S_HALT;
    endcase

    // Stores go straight from the fetch/indirect cycle into ST1.
    if (dispatch) begin
      case (disp_op)
        OP_ADD, OP_AND, OP_LDA: begin
          state_n = S_EXEC;
          abus_n  = disp_ea;
          rdm_n   = 1'b1;
        end
        OP_STA, OP_JSR: begin
          state_n = S_ST1;
          abus_n  = disp_ea;
          doe_n   = 1'b1;
          dout_n  = (disp_op == OP_STA) ? a : p_n;
        end
        default: state_n = S_EXEC;
      endcase
    end

    if (boundary) begin
      if (stop_sw || halt_now) begin
        state_n = S_HALT;
        run_n   = 1'b0;
      end else begin
        state_n = S_FETCH;
        abus_n  = p_n;
        rdm_n   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_HALT;
      p     <= '0;
      a     <= '0;
      c     <= 1'b0;
      ir    <= '0;
      ea    <= '0;
      run   <= 1'b0;
      abus  <= '0;
      rdm   <= 1'b0;
      wrm   <= 1'b0;
      doe   <= 1'b0;
      dout  <= '0;
    end else begin
      state <= state_n;
      p     <= p_n;
      a     <= a_n;
      c     <= c_n;
      ir    <= ir_n;
      ea    <= ea_n;
      run   <= run_n;
      abus  <= abus_n;
      rdm   <= rdm_n;
      wrm   <= wrm_n;
      doe   <= doe_n;
      dout  <= dout_n;
    end
  end

  always_ff @(posedge clk) begin
    dep_q   <= dep_sw;
    incp_q  <= incp_sw;
    start_q <= start_sw;
  end

endmodule

// File: tb/tb_q2_core.sv
// Directed bench for q2_core with a 4096x12 behavioural memory on the shared bus.
module tb_q2_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] sw = '0;
  logic        incp_sw = 1'b0, dep_sw = 1'b0, start_sw = 1'b0, stop_sw = 1'b0;
  wire  [11:0] dbus;
  logic [11:0] abus;
  logic        rdm, wrm, run;

  logic [11:0] mem [4096];
  logic [11:0] last_wa, last_wd;
  int          n_cmp = 0, n_bad = 0, wr_cnt = 0, excl_viol = 0;

  q2_core dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .dbus     (dbus),
    .abus     (abus),
    .rdm      (rdm),
    .wrm      (wrm),
    .incp_sw  (incp_sw),
    .dep_sw   (dep_sw),
    .start_sw (start_sw),
    .stop_sw  (stop_sw),
    .run      (run)
  );

  always #5 clk = ~clk;

  assign dbus = rdm ? mem[abus] : 12'hzzz;

  always @(posedge wrm) begin
    mem[abus] = dbus;
    last_wa   = abus;
    last_wd   = dbus;
    wr_cnt++;
  end

  always @(negedge clk) if (rdm && wrm) excl_viol++;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 = deposit, 1 = increment P, other = start
  task automatic pulse(input int unsigned which, input int hold);
    @(negedge clk);
    case (which)
      0: dep_sw = 1'b1;
      1: incp_sw = 1'b1;
      default: start_sw = 1'b1;
    endcase
    ticks(hold);
    dep_sw   = 1'b0;
    incp_sw  = 1'b0;
    start_sw = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic goto_p(input int unsigned addr);
    do_reset();
    for (int unsigned i = 0; i < addr; i++) pulse(1, 1);
  endtask

  // Counts clock cycles with run high after a start press.
  task automatic run_prog(output int cycles);
    pulse(2, 1);
    cycles = 0;
    while (run && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc, base, k;
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    ticks(2);
    check_val("rst_abus", abus, 16'h000);
    check_val("rst_rdm", rdm, 16'h0);
    check_val("rst_wrm", wrm, 16'h0);
    check_val("rst_run", run, 16'h0);
    check_val("rst_doe", dut.doe, 16'h0);
    check_val("rst_p", dut.p, 16'h000);
    rst = 1'b1;

    // Panel deposit of HLT at 0, then execute it
    sw = 12'hF00;
    pulse(0, 1);
    ticks(4);
    check_val("dep_mem0", mem[0], 16'hF00);
    check_val("dep_p", dut.p, 16'h001);
    check_val("dep_wrcnt", wr_cnt, 16'd1);
    do_reset();
    base = wr_cnt;
    run_prog(cyc);
    check_val("hlt_cycles", cyc, 16'd2);
    check_val("hlt_p", dut.p, 16'h001);
    check_val("hlt_nowr", wr_cnt - base, 16'd0);

    // LDA/ADD/STA to 0xFFF from the top page
    mem[12'hF80] = 12'h610;
    mem[12'hF81] = 12'h211;
    mem[12'hF82] = 12'h8FF;
    mem[12'hF83] = 12'hF00;
    mem[12'h010] = 12'h7FF;
    mem[12'h011] = 12'h001;
    goto_p(12'hF80);
    base = wr_cnt;
    run_prog(cyc);
    check_val("prog_wrcnt", wr_cnt - base, 16'd1);
    check_val("prog_waddr", last_wa, 16'hFFF);
    check_val("prog_wdata", last_wd, 16'h800);
    check_val("prog_c", dut.c, 16'h0);
    check_val("prog_a", dut.a, 16'h800);
    check_val("prog_cycles", cyc, 16'd9);

    // LDA I 0x020
    mem[0] = 12'h720;
    mem[1] = 12'hF00;
    mem[12'h020] = 12'h050;
    mem[12'h050] = 12'h123;
    do_reset();
    run_prog(cyc);
`ifdef Q2_INDIRECT_EN
    check_val("ind_a", dut.a, 16'h123);
    check_val("ind_cycles", cyc, 16'd5);
`else
    check_val("ind_a", dut.a, 16'h050);
    check_val("ind_cycles", cyc, 16'd4);
`endif

    // INA+SZA on 0xFFF skips the HLT at 2
    mem[0] = 12'h610;
    mem[1] = 12'hE48;
    mem[2] = 12'hF00;
    mem[3] = 12'hF00;
    mem[12'h010] = 12'hFFF;
    do_reset();
    run_prog(cyc);
    check_val("opr_a", dut.a, 16'h000);
    check_val("opr_c", dut.c, 16'h1);
    check_val("opr_skip_p", dut.p, 16'h004);

    // JSR 0x030 from P=5
    mem[5] = 12'hC30;
    mem[12'h030] = 12'h000;
    mem[12'h031] = 12'hF00;
    goto_p(5);
    run_prog(cyc);
    check_val("jsr_link", mem[12'h030], 16'h006);
    check_val("jsr_p", dut.p, 16'h032);
    check_val("jsr_cycles", cyc, 16'd5);

    // Stop a JMP 0 loop, then a held incp press
    mem[0] = 12'hA00;
    do_reset();
    pulse(2, 1);
    ticks(5);
    stop_sw = 1'b1;
    k = 0;
    while (run && k < 20) begin
      k++;
      @(negedge clk);
    end
    check_val("stop_run", run, 16'h0);
    check_val("stop_p", dut.p, 16'h000);
    stop_sw = 1'b0;
    pulse(1, 3);
    ticks(2);
    check_val("incp_p", dut.p, 16'h001);

    // Reset during a store
    mem[0] = 12'h840;
    do_reset();
    pulse(2, 1);
    k = 0;
    while (!wrm && k < 20) begin
      k++;
      @(negedge clk);
    end
    check_val("st_wrm_seen", wrm, 16'h1);
    rst = 1'b0;
    @(negedge clk);
    check_val("strst_wrm", wrm, 16'h0);
    check_val("strst_doe", dut.doe, 16'h0);
    check_val("strst_run", run, 16'h0);
    rst = 1'b1;
    ticks(2);

    check_val("rdm_wrm_excl", excl_viol, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
